// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and constants for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

  localparam int MEM_AW_DEFAULT = 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RMW  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Size codes that are meaningless for the given direction.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (we && ((f3 == F3_BU) || (f3 == F3_HU)))
      bad = 1'b1;
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if (((f3 == F3_H) || (f3 == F3_HU)) && lane[0])
      bad = 1'b1;
    if ((f3 == F3_W) && (lane != 2'b00))
      bad = 1'b1;
    return bad;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Purpose  : Core request/response channel plus data-RAM port of the LSU.
// Revision : 1.0
// ============================================================================
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

endinterface : lsu_if
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Lane extract/extend for loads and lane merge for sub-word stores.
// Revision : 1.0
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  wire logic [2:0]  i_f3,
  input  wire logic [1:0]  i_lane,
  input  wire logic [31:0] i_rdata,
  input  wire logic [31:0] i_wdata,
  output logic      [31:0] o_load_data,
  output logic      [31:0] o_merge_data
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  // Halfwords are only ever legal at lane 0 or 2, so the upper lane bit alone picks the half.
  assign w_byte_sh   = {i_lane, 3'b000};
  assign w_half_sh   = {i_lane[1], 4'b0000};
  assign w_shifted   = i_rdata >> w_byte_sh;
  assign w_byte      = w_shifted[7:0];
  assign w_half      = i_rdata[w_half_sh +: 16];
  assign w_byte_mask = 32'h0000_00FF << w_byte_sh;
  assign w_half_mask = 32'h0000_FFFF << w_half_sh;

  always_comb begin
    o_load_data = i_rdata;
    case (i_f3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  always_comb begin
    o_merge_data = i_wdata;
    case (i_f3[1:0])
      2'b00: o_merge_data = (i_rdata & ~w_byte_mask)
                          | ({24'h0, i_wdata[7:0]} << w_byte_sh);
      2'b01: o_merge_data = (i_rdata & ~w_half_mask)
                          | ({16'h0, i_wdata[15:0]} << w_half_sh);
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32 load/store unit in front of a single-port word RAM without
//            byte enables; sub-word stores are done as read-modify-write.
// Revision : 1.0
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  lsu_if.slave      bus
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;

  logic [MEM_AW-1:0] r_index;
  logic [1:0]        r_lane;
  logic [2:0]        r_f3;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic [MEM_AW-1:0] w_req_index;
  logic              w_range_err;
  logic              w_req_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

  assign w_ready     = (r_state == ST_IDLE) && !rst;
  assign w_accept    = bus.req_valid && w_ready;
  assign w_req_index = bus.req_addr[MEM_AW+1:2];
  assign w_range_err = (bus.req_addr >> (MEM_AW + 2)) != 32'h0;
  assign w_req_err   = w_range_err
                     || f3_illegal(bus.req_we, bus.req_funct3)
                     || f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);

  lsu_align u_align (
    .i_f3         (r_f3),
    .i_lane       (r_lane),
    .i_rdata      (bus.mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_lane  <= 2'b00;
      r_f3    <= 3'b000;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_index <= w_req_index;
        r_lane  <= bus.req_addr[1:0];
        r_f3    <= bus.req_funct3;
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = w_ready;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'(r_index);
    bus.mem_wdata  = 32'h0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'h0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            // Rejected requests leave the RAM port untouched.
            w_state_nxt = ST_DONE;
          end else begin
            bus.mem_addr = 32'(w_req_index);
            if (!bus.req_we) begin
              w_state_nxt = ST_LOAD;
            end else if (bus.req_funct3 == F3_W) begin
              bus.mem_we    = 1'b1;
              bus.mem_wdata = bus.req_wdata;
              w_state_nxt   = ST_DONE;
            end else begin
              w_state_nxt = ST_RMW;
            end
          end
        end
      end
      ST_LOAD: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = w_load_data;
        w_state_nxt    = ST_IDLE;
      end
      ST_RMW: begin
        // mem_rdata here is the word read on the accept edge.
        bus.mem_we    = 1'b1;
        bus.mem_wdata = w_merge_data;
        w_state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule : lsu
`default_nettype wire
